// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - Wishbone classic bus bundle between the load/store unit and the data RAM
interface wishbone_if;
  logic        cycle;
  logic        strobe;
  logic        write_enable;
  logic [3:0]  select;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        ack;
  logic [31:0] data_out;

  modport master (
    output cycle, strobe, write_enable, select, address, data_in,
    input  ack, data_out
  );

  modport slave (
    input  cycle, strobe, write_enable, select, address, data_in,
    output ack, data_out
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store request to single Wishbone classic cycle, with error response
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  wishbone_if.master  wishbone
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         cyc_q, cyc_d;
  logic         we_q, we_d;
  logic [3:0]   sel_q, sel_d;
  logic [31:0]  adr_q, adr_d;
  logic [31:0]  wdat_q, wdat_d;
  logic [1:0]   off_q, off_d;
  logic [1:0]   size_q, size_d;
  logic         uns_q, uns_d;
  logic         write_q, write_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic         misaligned;
  logic         timeout_hit;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;
  logic [31:0]  load_val;

  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_address[0]) ||
                      ((req_size == 2'b10) && (req_address[1:0] != 2'b00));

  // Terminal count is one less than the limit: BUS lasts exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TERM_COUNT);

  assign lane_b = wishbone.data_out[{off_q, 3'b000} +: 8];
  assign lane_h = off_q[1] ? wishbone.data_out[31:16] : wishbone.data_out[15:0];

  always_comb begin
    load_val = wishbone.data_out;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = wishbone.data_out;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d   = req_address[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          write_d = req_write;
          rdata_d = 32'h0;
          cnt_d   = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            cyc_d   = 1'b1;
            we_d    = req_write;
            adr_d   = {req_address[31:2], 2'b00};
            case (req_size)
              2'b00: begin
                sel_d  = 4'b0001 << req_address[1:0];
                wdat_d = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                sel_d  = 4'b0011 << req_address[1:0];
                wdat_d = {2{req_wdata[15:0]}};
              end
              default: begin
                sel_d  = 4'b1111;
                wdat_d = req_wdata;
              end
            endcase
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (wishbone.ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = write_q ? 32'h0 : load_val;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

  assign wishbone.cycle        = cyc_q;
  assign wishbone.strobe       = cyc_q;
  assign wishbone.write_enable = we_q;
  assign wishbone.select       = sel_q;
  assign wishbone.address      = adr_q;
  assign wishbone.data_in      = wdat_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench for load_store_unit against a small Wishbone RAM model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_address = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int tests_run = 0;
  int tests_failed = 0;
  int stale_strobes = 0;

  wishbone_if wb ();

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .wishbone     (wb)
  );

  always #5 clk = ~clk;

  // RAM slave: acks in the third strobe cycle, updated on the falling edge.
  logic [31:0] mem [0:15];
  logic        ack_gen = 1'b0;
  logic        spur_ack = 1'b0;
  logic        slave_mute = 1'b0;
  int          wcnt = 0;

  assign wb.ack = ack_gen | spur_ack;

  always @(negedge clk) begin
    if (wb.cycle && wb.strobe && !ack_gen && !slave_mute) begin
      if (wcnt == 2) begin
        ack_gen = 1'b1;
        wcnt = 0;
        if (wb.write_enable) begin
          for (int i = 0; i < 4; i++)
            if (wb.select[i]) mem[wb.address[5:2]][8*i +: 8] = wb.data_in[8*i +: 8];
          wb.data_out = 32'h0;
        end else begin
          wb.data_out = mem[wb.address[5:2]];
        end
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      ack_gen = 1'b0;
      wcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] r_rdata;
  logic        r_err;
  int          r_lat;
  logic        r_saw_cyc;
  int          r_stb_cnt;
  logic [3:0]  r_sel;
  logic [31:0] r_din;

  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
    logic got;
    logic prev_ack;
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = u; req_address = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0; r_saw_cyc = 1'b0; r_stb_cnt = 0; got = 1'b0; prev_ack = 1'b0;
    r_rdata = 32'hx; r_err = 1'bx; r_sel = 4'h0; r_din = 32'h0;
    while (!got && r_lat < 40) begin
      @(negedge clk);
      #1;
      r_lat++;
      if (wb.cycle) begin
        r_saw_cyc = 1'b1;
        r_sel = wb.select;
        r_din = wb.data_in;
      end
      if (wb.strobe) r_stb_cnt++;
      if (prev_ack && wb.strobe) stale_strobes++;
      prev_ack = wb.ack;
      if (resp_valid) begin
        got = 1'b1;
        r_rdata = resp_rdata;
        r_err = resp_error;
      end
    end
    if (!got) check("resp_wait_expired", 32'(got), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_cycle", 32'(wb.cycle), 32'd0);
    check("rst_strobe", 32'(wb.strobe), 32'd0);
    check("rst_we", 32'(wb.write_enable), 32'd0);
    check("rst_select", 32'(wb.select), 32'd0);
    check("rst_address", wb.address, 32'h0);
    check("rst_data_in", wb.data_in, 32'h0);
    reset_n = 1'b1;

    // Word store/load at 0x10
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_err", 32'(r_err), 32'd0);
    check("sw_sel", 32'(r_sel), 32'h0000000F);
    check("sw_din", r_din, 32'hDEADBEEF);
    check("sw_lat", 32'(r_lat), 32'd4);
    check("sw_rdata", r_rdata, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rdata", r_rdata, 32'hDEADBEEF);
    check("lw_lat", 32'(r_lat), 32'd4);
    check("lw_err", 32'(r_err), 32'd0);

    // Byte at 0x13 over a zero word
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080);
    check("sb_sel", 32'(r_sel), 32'h00000008);
    check("sb_din", r_din, 32'h80808080);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("sb_word", r_rdata, 32'h80000000);
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_signed", r_rdata, 32'hFFFFFF80);
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lbu", r_rdata, 32'h00000080);
    run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    check("lbu_lane0", r_rdata, 32'h00000000);

    // Halfword at 0x2
    run_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h00001234);
    run_req(1'b1, 2'b01, 1'b0, 32'h2, 32'h00008001);
    check("sh_sel", 32'(r_sel), 32'h0000000C);
    check("sh_din", r_din, 32'h80018001);
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("sh_word", r_rdata, 32'h80011234);
    run_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    check("lh_signed", r_rdata, 32'hFFFF8001);
    run_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
    check("lhu", r_rdata, 32'h00008001);
    run_req(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
    check("lh_low", r_rdata, 32'h00001234);

    // Misaligned and illegal
    run_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
    check("mis_w_err", 32'(r_err), 32'd1);
    check("mis_w_lat", 32'(r_lat), 32'd1);
    check("mis_w_cyc", 32'(r_saw_cyc), 32'd0);
    check("mis_w_rdata", r_rdata, 32'h0);
    run_req(1'b1, 2'b01, 1'b0, 32'h7, 32'h1234);
    check("mis_h_err", 32'(r_err), 32'd1);
    check("mis_h_lat", 32'(r_lat), 32'd1);
    check("mis_h_cyc", 32'(r_saw_cyc), 32'd0);
    run_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check("ill_err", 32'(r_err), 32'd1);
    check("ill_lat", 32'(r_lat), 32'd1);
    check("ill_cyc", 32'(r_saw_cyc), 32'd0);

    // Timeout with a silent slave, then a normal follow-up
    slave_mute = 1'b1;
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("to_err", 32'(r_err), 32'd1);
    check("to_stb_cycles", 32'(r_stb_cnt), 32'd8);
    check("to_lat", 32'(r_lat), 32'd9);
    check("to_rdata", r_rdata, 32'h0);
    slave_mute = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("to_follow_rdata", r_rdata, 32'h80011234);
    check("to_follow_err", 32'(r_err), 32'd0);

    // Spurious ack in IDLE
    @(negedge clk);
    spur_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_no_resp", 32'(resp_valid), 32'd0);
    end
    spur_ack = 1'b0;
    @(negedge clk);
    check("spur_ready", 32'(req_ready), 32'd1);

    // Reset during BUS
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_address = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rb_cycle_before", 32'(wb.cycle), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rb_cycle_async", 32'(wb.cycle), 32'd0);
    check("rb_strobe_async", 32'(wb.strobe), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rb_no_resp", 32'(resp_valid), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rb_no_resp_after", 32'(resp_valid), 32'd0);
    end
    check("rb_ready", 32'(req_ready), 32'd1);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("rb_follow_rdata", r_rdata, 32'h80000000);

    check("stale_strobe", 32'(stale_strobes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
